// File: rtl/s1s2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : s1s2_pkg
//  Description : Constants and FSM state type shared by both ends of the
//                S1->S2 serial link (frame geometry, bank size).
//  Revision    : 1.0 - initial release
// ============================================================================
package s1s2_pkg;

    localparam int AW        = 3;        // address bits per frame / RB width
    localparam int DW        = 18;       // data bits per frame / RB word width
    localparam int N_WORDS   = 8;        // words transferred per session
    localparam int FRAME_LEN = AW + DW;  // bits with sen low per frame

    typedef enum logic [1:0] {
        RD   = 2'd0,   // bank address presented, waiting for read data
        SEND = 2'd1,   // shifting frame bits out
        GAP  = 2'd2,   // one idle cycle between frames
        DONE = 2'd3    // all words sent
    } s1_state_t;

endpackage
`default_nettype wire

// File: rtl/s1_piso.sv
`default_nettype none
// ============================================================================
//  Module      : s1_piso
//  Description : Parallel-load, MSB-first shift register. Zeros are shifted
//                in at the LSB end, so after WIDTH shifts the MSB reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module s1_piso #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] r_q;

    // Load has priority over shift; both are single-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift) begin
            r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/s1_tx.sv
`default_nettype none
// ============================================================================
//  Module      : s1_tx
//  Description : S1 side of the S1->S2 serial link. Reads the N_WORDS words
//                of bank RB1 and sends each as a frame of AW address bits
//                followed by DW data bits (both MSB first) on sen/sd, then
//                raises S1_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module s1_tx #(
    parameter int AW      = s1s2_pkg::AW,
    parameter int DW      = s1s2_pkg::DW,
    parameter int N_WORDS = s1s2_pkg::N_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    output logic          RB1_RW,
    output logic [AW-1:0] RB1_A,
    input  logic [DW-1:0] RB1_Q,
    output logic          sen,
    output logic          sd,
    output logic          S1_done
);

    import s1s2_pkg::*;

    localparam int            c_FRAME_LEN = AW + DW;
    localparam int            c_BW        = $clog2(c_FRAME_LEN);
    localparam logic [c_BW-1:0] c_LAST_BIT  = c_BW'(c_FRAME_LEN - 1);
    localparam logic [AW-1:0]   c_LAST_WORD = AW'(N_WORDS - 1);

    s1_state_t          r_state,   w_state_n;
    logic               r_rd_wait, w_rd_wait_n;
    logic [AW-1:0]      r_word,    w_word_n;
    logic [c_BW-1:0]    r_bit,     w_bit_n;
    logic [AW-1:0]      r_addr,    w_addr_n;
    logic               r_sen,     w_sen_n;
    logic               r_done,    w_done_n;

    logic                 w_load;
    logic                 w_shift;
    logic [AW-1:0]        w_load_word;
    logic [c_FRAME_LEN-1:0] w_load_data;
    logic                 w_msb;

    // Frame image: address field is the word counter, never a readback of RB1_A.
    assign w_load_data = {w_load_word, RB1_Q};

    s1_piso #(
        .WIDTH (c_FRAME_LEN)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .d     (w_load_data),
        .msb   (w_msb)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RD;
            r_rd_wait <= 1'b0;
            r_word    <= '0;
            r_bit     <= '0;
            r_addr    <= '0;
            r_sen     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_rd_wait <= w_rd_wait_n;
            r_word    <= w_word_n;
            r_bit     <= w_bit_n;
            r_addr    <= w_addr_n;
            r_sen     <= w_sen_n;
            r_done    <= w_done_n;
        end
    end

    // Next-state logic and shift-register controls.
    always_comb begin
        w_state_n   = r_state;
        w_rd_wait_n = r_rd_wait;
        w_word_n    = r_word;
        w_bit_n     = r_bit;
        w_addr_n    = r_addr;
        w_sen_n     = r_sen;
        w_done_n    = r_done;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_word = r_word;

        case (r_state)
            RD: begin
                // First cycle after reset only lets the RB1 read data settle.
                if (!r_rd_wait) begin
                    w_rd_wait_n = 1'b1;
                end else begin
                    w_rd_wait_n = 1'b0;
                    w_load      = 1'b1;
                    w_sen_n     = 1'b0;
                    w_bit_n     = '0;
                    w_state_n   = SEND;
                    // Prefetch the next word; the address saturates at the last one.
                    if (r_addr != c_LAST_WORD) begin
                        w_addr_n = r_addr + 1'b1;
                    end
                end
            end

            SEND: begin
                // The shift on the final bit empties the register, so sd drops to 0.
                w_shift = 1'b1;
                if (r_bit == c_LAST_BIT) begin
                    w_sen_n = 1'b1;
                    if (r_word == c_LAST_WORD) begin
                        // Last frame: done rises together with the final sen rise.
                        w_state_n = DONE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = GAP;
                    end
                end else begin
                    w_bit_n = r_bit + 1'b1;
                end
            end

            GAP: begin
                if (r_word < c_LAST_WORD) begin
                    // RB1_A was advanced at the previous load, so RB1_Q is already valid.
                    w_word_n    = r_word + 1'b1;
                    w_load_word = r_word + 1'b1;
                    w_load      = 1'b1;
                    w_sen_n     = 1'b0;
                    w_bit_n     = '0;
                    w_state_n   = SEND;
                    if (r_addr != c_LAST_WORD) begin
                        w_addr_n = r_addr + 1'b1;
                    end
                end else begin
                    w_state_n = DONE;
                    w_done_n  = 1'b1;
                end
            end

            DONE: begin
                w_sen_n  = 1'b1;
                w_done_n = 1'b1;
            end

            default: begin
                w_state_n = RD;
            end
        endcase
    end

    assign RB1_RW  = 1'b1;
    assign RB1_A   = r_addr;
    assign sen     = r_sen;
    assign sd      = w_msb;
    assign S1_done = r_done;

endmodule
`default_nettype wire
